// File: rtl/gb_out_stream_sink.sv
// gb_out_stream_sink: receives one Gaussian-blur output frame per start
// pulse, tracks the row/col position of the next expected pixel, folds each
// accepted pixel into a rotate-add checksum and flags TLAST misplacement.
// Optional feature macro: GB_SINK_BP_EN (LFSR-driven TREADY backpressure).
module gb_out_stream_sink #(
    parameter int          OUT_COLS  = 640,
    parameter int          OUT_ROWS  = 480,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    input  logic [1:0]  bp_density,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic [19:0] px_count,
    output logic [31:0] checksum,
    output logic        busy,
    output logic        frame_done,
    output logic        tlast_err
);

    localparam logic [9:0] COL_MAX = 10'(OUT_COLS - 1);
    localparam logic [9:0] ROW_MAX = 10'(OUT_ROWS - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
    state_t state;

    logic beat;
    logic last_pos;
    logic ready_calc;

    assign beat     = (state == RECV) && s_tvalid && s_tready;
    assign last_pos = (row == ROW_MAX) && (col == COL_MAX);

`ifdef GB_SINK_BP_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11 in 1-based numbering
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Pseudo-random stall source; only advances while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (state == RECV) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign ready_calc = (bp_density == 2'd0) ? 1'b1 : (lfsr[1:0] >= bp_density);
`else
    logic unused_bp;
    assign unused_bp  = ^{bp_density, LFSR_SEED};
    assign ready_calc = 1'b1;
`endif

    // Frame FSM with registered ready, position, checksum and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            px_count   <= '0;
            checksum   <= '0;
            s_tready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tlast_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RECV;
                        col        <= '0;
                        row        <= '0;
                        px_count   <= '0;
                        checksum   <= '0;
                        tlast_err  <= 1'b0;
                        frame_done <= 1'b0;
                        busy       <= 1'b1;
                        s_tready   <= ready_calc;
                    end
                end
                RECV: begin
                    s_tready <= ready_calc;
                    if (beat) begin
                        checksum <= {checksum[30:0], checksum[31]} + {24'd0, s_tdata};
                        px_count <= px_count + 20'd1;
                        // TLAST must coincide exactly with the count-based last pixel
                        if (s_tlast != last_pos) begin
                            tlast_err <= 1'b1;
                        end
                        if (last_pos) begin
                            col        <= '0;
                            row        <= '0;
                            state      <= DONE;
                            s_tready   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else if (col == COL_MAX) begin
                            col <= '0;
                            row <= row + 10'd1;
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_out_stream_sink.sv
// Directed bench for gb_out_stream_sink with a 4x2 frame.
module tb_gb_out_stream_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [1:0]  bp_density = 2'd0;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [19:0] px_count;
    logic [31:0] checksum;
    logic        busy;
    logic        frame_done;
    logic        tlast_err;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    gb_out_stream_sink #(.OUT_COLS(4), .OUT_ROWS(2), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .bp_density(bp_density), .col(col), .row(row), .px_count(px_count),
        .checksum(checksum), .busy(busy), .frame_done(frame_done), .tlast_err(tlast_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        n = 0;
        if (bp_density == 2'd0) chk("rdy_no_bp", {31'd0, s_tready}, 32'd1);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= 200) chk("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int tlast_at);
        for (int i = 1; i <= 8; i++) send(8'(i), i == tlast_at);
    endtask

    task automatic check_done(input string tag, input logic [31:0] cs, input logic err);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_cnt"}, {12'd0, px_count}, 32'd8);
        chk({tag, "_cs"}, checksum, cs);
        chk({tag, "_err"}, {31'd0, tlast_err}, {31'd0, err});
        chk({tag, "_rdy"}, {31'd0, s_tready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] ff_cs;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'd0, s_tready}, 32'd0);
        chk("rst_cs", checksum, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean frame 1..8
        do_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_rdy", {31'd0, s_tready}, 32'd1);
        send_frame(8);
        check_done("t1", 32'h1F6, 1'b0);
        chk("t1_pos", {12'd0, row, col}, 32'd0);

        // 2: tlast misplaced; start clears flags
        do_start();
        chk("t2_clr_done", {31'd0, frame_done}, 32'd0);
        chk("t2_clr_cnt", {12'd0, px_count}, 32'd0);
        send_frame(4);
        check_done("t2", 32'h1F6, 1'b1);

        // 3: row wrap and ignored start during RECV
        do_start();
        chk("t3_clr_err", {31'd0, tlast_err}, 32'd0);
        for (int i = 1; i <= 3; i++) send(8'(i), 1'b0);
        chk("t3_col3", {22'd0, col}, 32'd3);
        chk("t3_row0", {22'd0, row}, 32'd0);
        send(8'd4, 1'b0);
        chk("t3_col0", {22'd0, col}, 32'd0);
        chk("t3_row1", {22'd0, row}, 32'd1);
        do_start();
        chk("t3_ign_cnt", {12'd0, px_count}, 32'd4);
        chk("t3_ign_cs", checksum, 32'd26);
        for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
        check_done("t3", 32'h1F6, 1'b0);

        // 4: async reset mid-frame, then full frame
        do_start();
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_cnt", {12'd0, px_count}, 32'd0);
        chk("t4_rst_cs", checksum, 32'd0);
        chk("t4_rst_rdy", {31'd0, s_tready}, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        chk("t4_rst_col", {22'd0, col}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_frame(8);
        check_done("t4", 32'h1F6, 1'b0);

        // 6 (scaled): all-0xFF frame, expected checksum from rotate-add model
        ff_cs = 32'd0;
        for (int i = 0; i < 8; i++) ff_cs = {ff_cs[30:0], ff_cs[31]} + 32'hFF;
        do_start();
        for (int i = 1; i <= 8; i++) send(8'hFF, i == 8);
        check_done("t6", ff_cs, 1'b0);

`ifdef GB_SINK_BP_EN
        // 5: heavy backpressure
        bp_density = 2'd3;
        stalls = 0;
        do_start();
        send_frame(8);
        check_done("t5", 32'h1F6, 1'b0);
        chk("t5_stalled", {31'd0, stalls > 0}, 32'd1);
        bp_density = 2'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
